any1_dispatch: RTL

- Consumer end of the instruction scheduler's selection output.
- Accepts the selected ROB index each cycle and pulses "mark out" back to the ROB.
- Buffers accepted indices in a small in-order FIFO and hands them to the execute unit over a valid/ready handshake.
- Tracks in-flight operations and returns completion (writeback) pulses to the ROB.

---
 rtl/any1_dispatch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/any1_dispatch.sv
// Dispatch stage: accepts scheduler selections, buffers them in order and issues them to the execute unit.
// Define ANY1_DISPATCH_PERF_EN to add the issued/stall performance counters.
module any1_dispatch #(
    parameter int ROB_ENTRIES = 64,
    parameter int QDEPTH      = 4,
    parameter int MAX_OUT     = 8,
    localparam int RW         = $clog2(ROB_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW:0]   sel_i,
    input  logic          flush_i,
    output logic          out_v_o,
    output logic [RW-1:0] out_rid_o,
    output logic          fu_valid_o,
    output logic [RW-1:0] fu_rid_o,
    input  logic          fu_ready_i,
    input  logic          fu_done_i,
    input  logic [RW-1:0] fu_done_rid_i,
    output logic          wb_v_o,
    output logic [RW-1:0] wb_rid_o,
    output logic          full_o,
    output logic          err_o
`ifdef ANY1_DISPATCH_PERF_EN
    ,
    output logic [31:0]   perf_issued_o,
    output logic [31:0]   perf_stall_o
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int DW = CW + 4;

    logic [RW-1:0]          r_mem [QDEPTH];
    logic [PW:0]            r_wptr;
    logic [PW:0]            r_rptr;
    logic [ROB_ENTRIES-1:0] r_busy;
    logic [CW-1:0]          r_inflight;
    logic [DW-1:0]          r_drain;
    logic                   r_err;
    logic                   r_out_v;
    logic [RW-1:0]          r_out_rid;
    logic                   r_wb_v;
    logic [RW-1:0]          r_wb_rid;

    logic          w_sel_v;
    logic [RW-1:0] w_sel_rid;
    logic          w_empty;
    logic          w_full;
    logic          w_fu_valid;
    logic          w_xfer;
    logic          w_accept;
    logic          w_drain_done;
    logic          w_done_hit;
    logic          w_done_bad;

    assign w_sel_v    = ~sel_i[RW];
    assign w_sel_rid  = sel_i[RW-1:0];
    // Extra pointer bit tells full from empty when the indices match.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_fu_valid = !w_empty && (r_inflight < CW'(MAX_OUT));
    assign w_xfer     = w_fu_valid && fu_ready_i;
    assign w_accept   = w_sel_v && !r_busy[w_sel_rid] && !w_full && !flush_i;

    // Completions while draining belong to ops that a flush already discarded.
    assign w_drain_done = fu_done_i && (r_drain != '0);
    assign w_done_hit   = fu_done_i && (r_drain == '0) && r_busy[fu_done_rid_i];
    assign w_done_bad   = fu_done_i && (r_drain == '0) && !r_busy[fu_done_rid_i];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr[PW-1:0]] <= w_sel_rid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_busy     <= '0;
            r_inflight <= '0;
            r_drain    <= '0;
            r_err      <= 1'b0;
            r_out_v    <= 1'b0;
            r_out_rid  <= '0;
            r_wb_v     <= 1'b0;
            r_wb_rid   <= '0;
        end else begin
            r_out_v   <= w_accept;
            r_out_rid <= w_accept ? w_sel_rid : '0;
            r_wb_v    <= w_done_hit && !flush_i;
            r_wb_rid  <= (w_done_hit && !flush_i) ? fu_done_rid_i : '0;
            if (w_done_bad) begin
                r_err <= 1'b1;
            end
            if (flush_i) begin
                // Everything still at the execute unit must be drained silently.
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_busy     <= '0;
                r_inflight <= '0;
                r_drain    <= r_drain - DW'(w_drain_done) + DW'(r_inflight)
                              + DW'(w_xfer) - DW'(w_done_hit);
            end else begin
                if (w_accept) begin
                    r_wptr              <= r_wptr + (PW+1)'(1);
                    r_busy[w_sel_rid]   <= 1'b1;
                end
                if (w_xfer) begin
                    r_rptr <= r_rptr + (PW+1)'(1);
                end
                if (w_done_hit) begin
                    r_busy[fu_done_rid_i] <= 1'b0;
                end
                r_inflight <= r_inflight + CW'(w_xfer) - CW'(w_done_hit);
                if (w_drain_done) begin
                    r_drain <= r_drain - DW'(1);
                end
            end
        end
    end

    assign out_v_o    = r_out_v;
    assign out_rid_o  = r_out_rid;
    assign wb_v_o     = r_wb_v;
    assign wb_rid_o   = r_wb_rid;
    assign fu_valid_o = w_fu_valid;
    assign fu_rid_o   = w_empty ? '0 : r_mem[r_rptr[PW-1:0]];
    assign full_o     = w_full;
    assign err_o      = r_err;

`ifdef ANY1_DISPATCH_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    // Counters survive flushes; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_xfer) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (w_sel_v && !w_accept) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued_o = r_perf_issued;
    assign perf_stall_o  = r_perf_stall;
`endif

endmodule
